// File: rtl/issue_age_scheduler_pkg.sv
// Shared constants and helpers for the age-ordered issue queue scheduler.
// Also used by the load/store queue's oldest-select logic.
package issue_age_scheduler_pkg;

  localparam int ISSUE_DEPTH = 16;
  localparam int ISSUE_IDX_W = 4;

  function automatic logic [ISSUE_IDX_W-1:0] onehot_to_idx(input logic [ISSUE_DEPTH-1:0] oh);
    logic [ISSUE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ISSUE_DEPTH; i++) begin
      if (oh[i]) idx = idx | ISSUE_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [ISSUE_IDX_W:0] popcount(input logic [ISSUE_DEPTH-1:0] v);
    logic [ISSUE_IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < ISSUE_DEPTH; i++) begin
      cnt = cnt + (ISSUE_IDX_W+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/age_oldest_select.sv
// Combinational oldest-candidate pick over a flattened age matrix.
// age[i*DEPTH+j] = 1 means slot i is older than slot j.
module age_oldest_select
  import issue_age_scheduler_pkg::*;
(
  input  logic [ISSUE_DEPTH-1:0]             cand,
  input  logic [ISSUE_DEPTH*ISSUE_DEPTH-1:0] age,
  output logic                               found,
  output logic [ISSUE_IDX_W-1:0]             idx,
  output logic [ISSUE_DEPTH-1:0]             onehot
);

  logic blocked;

  // A candidate wins when no other candidate is older than it.
  always_comb begin
    onehot  = '0;
    blocked = 1'b0;
    for (int i = 0; i < ISSUE_DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ISSUE_DEPTH; j++) begin
        blocked = blocked | (cand[j] & age[j*ISSUE_DEPTH+i]);
      end
      onehot[i] = cand[i] & ~blocked;
    end
    found = |onehot;
    idx   = onehot_to_idx(onehot);
  end

endmodule

// File: rtl/issue_age_scheduler.sv
// Oldest-first select and dealloc controller for the 16-entry issue queue,
// with a one-deep registered grant toward execute.
module issue_age_scheduler
  import issue_age_scheduler_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH,
  parameter int IDX_W = ISSUE_IDX_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] entry_ready,
  input  logic             exe_accept,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [DEPTH-1:0] dealloc_mask,
  output logic [DEPTH-1:0] occupied,
  output logic [IDX_W:0]   free_count,
  output logic             full,
  output logic             alloc_err
);

  logic [DEPTH*DEPTH-1:0] age_q;
  logic [DEPTH*DEPTH-1:0] age_d;
  logic [DEPTH-1:0]       occ_d;
  logic [DEPTH-1:0]       alloc_oh;
  logic [DEPTH-1:0]       deq_oh;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [DEPTH-1:0]       sel_onehot;
  logic                   load;
  logic                   deq;
  logic                   alloc_ok;
  logic                   alloc_bad;

  age_oldest_select u_select (
    .cand   (occupied & entry_ready),
    .age    (age_q),
    .found  (sel_found),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  assign full = &occupied;

  // A slot freed at this edge still counts as occupied, so allocating it is an error.
  always_comb begin
    load      = !STALL && (!grant_valid || exe_accept);
    deq       = load && sel_found;
    alloc_ok  = !STALL && alloc_valid && !occupied[alloc_idx];
    alloc_bad = !STALL && alloc_valid &&  occupied[alloc_idx];
    alloc_oh  = alloc_ok ? (DEPTH'(1) << alloc_idx) : '0;
    deq_oh    = deq ? sel_onehot : '0;
    occ_d     = (occupied & ~deq_oh) | alloc_oh;
    age_d     = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_oh[i]) age_d[i*DEPTH+j] = 1'b0;
        if (alloc_oh[j]) age_d[i*DEPTH+j] = occupied[i];
        if (deq_oh[i] || deq_oh[j]) age_d[i*DEPTH+j] = 1'b0;
      end
    end
  end

  // Grant register stage: selection result and queue state update together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      occupied     <= '0;
      age_q        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      dealloc_mask <= '0;
      alloc_err    <= 1'b0;
      free_count   <= (IDX_W+1)'(DEPTH);
    end else if (FLUSH) begin
      occupied     <= '0;
      age_q        <= '0;
      grant_valid  <= 1'b0;
      dealloc_mask <= '0;
      free_count   <= (IDX_W+1)'(DEPTH);
    end else begin
      occupied     <= occ_d;
      age_q        <= age_d;
      dealloc_mask <= deq_oh;
      free_count   <= (IDX_W+1)'(DEPTH) - popcount(occ_d);
      if (load) begin
        grant_valid <= sel_found;
        if (sel_found) grant_idx <= sel_idx;
      end
      if (alloc_bad) alloc_err <= 1'b1;
    end
  end

endmodule
